vga_scan_controller: RTL and testbench



---
 rtl/vga_scan_controller.sv | 159 +++++++++++++++
 tb/tb_vga_scan_controller.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_controller.sv
// Raster timing master: free-running h/v counters with x/y output, plus sync/blank
// delayed by PIPE_LAT ticks and an output register that lines up returned RGB.
module vga_scan_controller #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PIPE_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_en,
    output logic [9:0] x,
    output logic [9:0] y,
    input  logic [7:0] red,
    input  logic [7:0] green,
    input  logic [7:0] blue,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic       vga_sync_n,
    output logic       active,
    output logic       frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // 11-bit constants so a 1024-tick total or sync end does not wrap
    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
    localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0]          h_cnt_q, h_cnt_d;
    logic [9:0]          v_cnt_q, v_cnt_d;
    logic                active_q, active_d;
    logic                frame_start_q, frame_start_d;
    logic [PIPE_LAT-1:0] hs_pipe_q, hs_pipe_d;
    logic [PIPE_LAT-1:0] vs_pipe_q, vs_pipe_d;
    logic [PIPE_LAT-1:0] act_pipe_q, act_pipe_d;
    logic                vga_hs_q, vga_hs_d;
    logic                vga_vs_q, vga_vs_d;
    logic                vga_blank_n_q, vga_blank_n_d;
    logic [7:0]          vga_r_q, vga_r_d;
    logic [7:0]          vga_g_q, vga_g_d;
    logic [7:0]          vga_b_q, vga_b_d;

    logic [10:0] h_ext, v_ext;
    logic        h_wrap, v_wrap;
    logic        hs_raw, vs_raw, act_raw;

    always_comb begin
        h_ext   = {1'b0, h_cnt_q};
        v_ext   = {1'b0, v_cnt_q};
        h_wrap  = (h_ext == H_LAST);
        v_wrap  = (v_ext == V_LAST);
        hs_raw  = !((h_ext >= HS_BEG) && (h_ext < HS_END));
        vs_raw  = !((v_ext >= VS_BEG) && (v_ext < VS_END));
        act_raw = (h_ext < H_ACT) && (v_ext < V_ACT);
    end

    // Counters; 'active' is registered from the next count so it resets to 0
    always_comb begin
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        active_d      = active_q;
        frame_start_d = 1'b0;
        if (pix_en) begin
            if (h_wrap) begin
                h_cnt_d = '0;
                v_cnt_d = v_wrap ? '0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
            active_d      = ({1'b0, h_cnt_d} < H_ACT) && ({1'b0, v_cnt_d} < V_ACT);
            frame_start_d = h_wrap && v_wrap;
        end
    end

    // Delay line: bit 0 takes the raw value, bit i takes bit i-1
    always_comb begin
        hs_pipe_d     = hs_pipe_q;
        vs_pipe_d     = vs_pipe_q;
        act_pipe_d    = act_pipe_q;
        vga_hs_d      = vga_hs_q;
        vga_vs_d      = vga_vs_q;
        vga_blank_n_d = vga_blank_n_q;
        vga_r_d       = vga_r_q;
        vga_g_d       = vga_g_q;
        vga_b_d       = vga_b_q;
        if (pix_en) begin
            hs_pipe_d     = PIPE_LAT'({hs_pipe_q, hs_raw});
            vs_pipe_d     = PIPE_LAT'({vs_pipe_q, vs_raw});
            act_pipe_d    = PIPE_LAT'({act_pipe_q, act_raw});
            vga_hs_d      = hs_pipe_q[PIPE_LAT-1];
            vga_vs_d      = vs_pipe_q[PIPE_LAT-1];
            vga_blank_n_d = act_pipe_q[PIPE_LAT-1];
            vga_r_d       = act_pipe_q[PIPE_LAT-1] ? red   : 8'h00;
            vga_g_d       = act_pipe_q[PIPE_LAT-1] ? green : 8'h00;
            vga_b_d       = act_pipe_q[PIPE_LAT-1] ? blue  : 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            active_q      <= 1'b0;
            frame_start_q <= 1'b0;
            hs_pipe_q     <= '1;
            vs_pipe_q     <= '1;
            act_pipe_q    <= '0;
            vga_hs_q      <= 1'b1;
            vga_vs_q      <= 1'b1;
            vga_blank_n_q <= 1'b0;
            vga_r_q       <= 8'h00;
            vga_g_q       <= 8'h00;
            vga_b_q       <= 8'h00;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            active_q      <= active_d;
            frame_start_q <= frame_start_d;
            hs_pipe_q     <= hs_pipe_d;
            vs_pipe_q     <= vs_pipe_d;
            act_pipe_q    <= act_pipe_d;
            vga_hs_q      <= vga_hs_d;
            vga_vs_q      <= vga_vs_d;
            vga_blank_n_q <= vga_blank_n_d;
            vga_r_q       <= vga_r_d;
            vga_g_q       <= vga_g_d;
            vga_b_q       <= vga_b_d;
        end
    end

    assign x           = h_cnt_q;
    assign y           = v_cnt_q;
    assign active      = active_q;
    assign frame_start = frame_start_q;
    assign vga_hs      = vga_hs_q;
    assign vga_vs      = vga_vs_q;
    assign vga_blank_n = vga_blank_n_q;
    assign vga_r       = vga_r_q;
    assign vga_g       = vga_g_q;
    assign vga_b       = vga_b_q;
    assign vga_sync_n  = 1'b0;

endmodule

// File: tb/tb_vga_scan_controller.sv
// Bench for vga_scan_controller: default 640x480 instance plus two reduced-timing
// instances (PIPE_LAT 1 and 2), all checked each clock against an arithmetic raster model.
module tb_vga_scan_controller;
  localparam int SHA = 16, SHF = 2, SHS = 3, SHB = 3;
  localparam int SVA = 12, SVF = 2, SVS = 2, SVB = 3;
  localparam int SFT = (SHA + SHF + SHS + SHB) * (SVA + SVF + SVS + SVB);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_en = 1'b0;

  logic [9:0] ox[3], oy[3];
  logic [7:0] ir[3], ig[3], ib[3];
  logic [7:0] orr[3], og[3], ob[3];
  logic       ohs[3], ovs[3], obl[3], osn[3], oact[3], ofs[3];
  logic [9:0] xs[3][4], ys[3][4];

  int cfg_ha[3]  = '{640, SHA, SHA};
  int cfg_hf[3]  = '{16,  SHF, SHF};
  int cfg_hs[3]  = '{96,  SHS, SHS};
  int cfg_hb[3]  = '{48,  SHB, SHB};
  int cfg_va[3]  = '{480, SVA, SVA};
  int cfg_vf[3]  = '{10,  SVF, SVF};
  int cfg_vs[3]  = '{2,   SVS, SVS};
  int cfg_vb[3]  = '{33,  SVB, SVB};
  int cfg_lat[3] = '{1,   1,   2};

  int   vectors = 0;
  int   miscompares = 0;
  int   n = 0;
  logic last_pe = 1'b0;
  int   cyc = 0;
  int   ticks = 0;
  int   fs_ref = 0;
  logic meas_hs = 1'b0;
  logic prev_hs1 = 1'b1;
  int   last_fall = -1;
  int   nfalls = 0;

  always #5 clk = ~clk;

  vga_scan_controller #(.PIPE_LAT(1)) u_d0 (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .x(ox[0]), .y(oy[0]),
    .red(ir[0]), .green(ig[0]), .blue(ib[0]),
    .vga_r(orr[0]), .vga_g(og[0]), .vga_b(ob[0]),
    .vga_hs(ohs[0]), .vga_vs(ovs[0]), .vga_blank_n(obl[0]), .vga_sync_n(osn[0]),
    .active(oact[0]), .frame_start(ofs[0])
  );

  vga_scan_controller #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .PIPE_LAT(1)
  ) u_d1 (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .x(ox[1]), .y(oy[1]),
    .red(ir[1]), .green(ig[1]), .blue(ib[1]),
    .vga_r(orr[1]), .vga_g(og[1]), .vga_b(ob[1]),
    .vga_hs(ohs[1]), .vga_vs(ovs[1]), .vga_blank_n(obl[1]), .vga_sync_n(osn[1]),
    .active(oact[1]), .frame_start(ofs[1])
  );

  vga_scan_controller #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .PIPE_LAT(2)
  ) u_d2 (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .x(ox[2]), .y(oy[2]),
    .red(ir[2]), .green(ig[2]), .blue(ib[2]),
    .vga_r(orr[2]), .vga_g(og[2]), .vga_b(ob[2]),
    .vga_hs(ohs[2]), .vga_vs(ovs[2]), .vga_blank_n(obl[2]), .vga_sync_n(osn[2]),
    .active(oact[2]), .frame_start(ofs[2])
  );

  // Pixel source: returns x[7:0], y[7:0], 0x5A for the coordinate seen PIPE_LAT ticks ago
  always @(posedge clk) begin
    if (pix_en) begin
      for (int d = 0; d < 3; d++) begin
        xs[d][0] <= ox[d];
        ys[d][0] <= oy[d];
        for (int i = 1; i < 4; i++) begin
          xs[d][i] <= xs[d][i-1];
          ys[d][i] <= ys[d][i-1];
        end
      end
    end
  end

  always_comb begin
    ir[0] = xs[0][0][7:0];
    ig[0] = ys[0][0][7:0];
    ir[1] = xs[1][0][7:0];
    ig[1] = ys[1][0][7:0];
    ir[2] = xs[2][1][7:0];
    ig[2] = ys[2][1][7:0];
    ib[0] = 8'h5A;
    ib[1] = 8'h5A;
    ib[2] = 8'h5A;
  end

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  endtask

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s dut%0d n=%0d observed=%0h expected=%0h", tag, d, n, obs, exp);
    end
    if (miscompares >= 20) finish_run();
  endtask

  // Reference: n pix_en ticks since reset; outputs show the coordinate from n-PIPE_LAT-1
  task automatic check_all();
    for (int d = 0; d < 3; d++) begin
      int ht, vt, ex, ey, m, hh, vv;
      logic eact, efs, ehs, evs, ebl;
      logic [7:0] er, eg, eb;
      ht   = cfg_ha[d] + cfg_hf[d] + cfg_hs[d] + cfg_hb[d];
      vt   = cfg_va[d] + cfg_vf[d] + cfg_vs[d] + cfg_vb[d];
      ex   = n % ht;
      ey   = (n / ht) % vt;
      eact = (n > 0) && (ex < cfg_ha[d]) && (ey < cfg_va[d]);
      efs  = last_pe && (n > 0) && ((n % (ht * vt)) == 0);
      m    = n - cfg_lat[d] - 1;
      if (m < 0) begin
        ehs = 1'b1; evs = 1'b1; ebl = 1'b0;
      end else begin
        hh  = m % ht;
        vv  = (m / ht) % vt;
        ehs = !((hh >= cfg_ha[d] + cfg_hf[d]) && (hh < cfg_ha[d] + cfg_hf[d] + cfg_hs[d]));
        evs = !((vv >= cfg_va[d] + cfg_vf[d]) && (vv < cfg_va[d] + cfg_vf[d] + cfg_vs[d]));
        ebl = (hh < cfg_ha[d]) && (vv < cfg_va[d]);
      end
      er = ebl ? 8'(hh) : 8'h00;
      eg = ebl ? 8'(vv) : 8'h00;
      eb = ebl ? 8'h5A  : 8'h00;
      chk("x",           d, 32'(ox[d]),  32'(ex));
      chk("y",           d, 32'(oy[d]),  32'(ey));
      chk("active",      d, 32'(oact[d]), 32'(eact));
      chk("frame_start", d, 32'(ofs[d]), 32'(efs));
      chk("vga_hs",      d, 32'(ohs[d]), 32'(ehs));
      chk("vga_vs",      d, 32'(ovs[d]), 32'(evs));
      chk("vga_blank_n", d, 32'(obl[d]), 32'(ebl));
      chk("vga_sync_n",  d, 32'(osn[d]), 32'(0));
      chk("vga_r",       d, 32'(orr[d]), 32'(er));
      chk("vga_g",       d, 32'(og[d]),  32'(eg));
      chk("vga_b",       d, 32'(ob[d]),  32'(eb));
    end
  endtask

  task automatic step(input logic r, input logic p);
    rst_n  = r;
    pix_en = p;
    @(posedge clk);
    cyc++;
    if (!r) begin
      n = 0;
      last_pe = 1'b0;
    end else if (p) begin
      n++;
      ticks++;
      last_pe = 1'b1;
    end else begin
      last_pe = 1'b0;
    end
    #1;
    check_all();
    if (!r) begin
      fs_ref = ticks;
    end else if (ofs[1]) begin
      chk("fs_gap_ticks", 1, 32'(ticks - fs_ref), 32'(SFT));
      fs_ref = ticks;
    end
    if (meas_hs && prev_hs1 && !ohs[1]) begin
      if (last_fall >= 0) chk("hs_period_clks", 1, 32'(cyc - last_fall), 32'(2 * (SHA + SHF + SHS + SHB)));
      last_fall = cyc;
      nfalls++;
    end
    prev_hs1 = ohs[1];
  endtask

  initial begin
    repeat (5) step(1'b0, 1'b1);
    chk("rst_x",       0, 32'(ox[0]),  32'(0));
    chk("rst_y",       0, 32'(oy[0]),  32'(0));
    chk("rst_hs",      0, 32'(ohs[0]), 32'(1));
    chk("rst_vs",      0, 32'(ovs[0]), 32'(1));
    chk("rst_blank_n", 0, 32'(obl[0]), 32'(0));
    chk("rst_rgb",     0, 32'({orr[0], og[0], ob[0]}), 32'(0));

    repeat (3) step(1'b1, 1'b1);
    chk("x_after3", 0, 32'(ox[0]), 32'(3));

    while (n < 10 * 800 + 47 + 2) step(1'b1, 1'b1);
    chk("pix47_10_r", 0, 32'(orr[0]), 32'(8'h2F));
    chk("pix47_10_g", 0, 32'(og[0]),  32'(8'h0A));
    chk("pix47_10_b", 0, 32'(ob[0]),  32'(8'h5A));

    meas_hs = 1'b1;
    last_fall = -1;
    nfalls = 0;
    repeat (1000) begin
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
    end
    meas_hs = 1'b0;
    chk("hs_falls_seen", 1, 32'(nfalls >= 20), 32'(1));

    repeat (50) step(1'b1, 1'b0);

    repeat (3000) step(1'b1, $urandom_range(0, 3) != 0);

    begin
      int k = 0;
      while (!(ox[1] == 10'd10 && oy[1] == 10'd7) && k < 2000) begin
        step(1'b1, 1'b1);
        k++;
      end
      chk("midframe_reached", 1, 32'(k < 2000), 32'(1));
    end
    step(1'b0, 1'b1);
    chk("midrst_x",       1, 32'(ox[1]),  32'(0));
    chk("midrst_y",       1, 32'(oy[1]),  32'(0));
    chk("midrst_blank_n", 1, 32'(obl[1]), 32'(0));
    repeat (1000) step(1'b1, 1'b1);

    repeat (6000) step($urandom_range(0, 499) != 0, 1'($urandom_range(0, 1)));

    finish_run();
  end
endmodule
